// File: rtl/clb_config_chain_if.sv
// Shared serial configuration bus for CLB tiles.
// The loader drives the program strobe and the serial data/valid pair.
// Every tile on the chain observes the same three wires.
interface clb_config_chain_if;
  logic prgm_b;
  logic bit_in;
  logic bit_valid;

  modport master (
    output prgm_b,
    output bit_in,
    output bit_valid
  );

  modport slave (
    input prgm_b,
    input bit_in,
    input bit_valid
  );
endinterface

// File: rtl/clb_config_chain.sv
// Serial configuration loader for one CLB tile.
// It shifts one frame off the shared bus: the LUT truth table, the output-mux
// select and the interconnect selects, sent first bit first.
// Tiles are daisy-chained through cfg_en_in/cfg_en_out.
// The active outputs are double-buffered and only change on commit, which is
// when prgm_b returns high while the tile is in DONE.
// Optional feature macro: CFG_PARITY_EN.
//   - It adds one trailing even-parity bit to the frame and an ERR state.
//   - A frame with bad parity halts the chain and raises cfg_err.
module clb_config_chain #(
  parameter int LUT_K  = 4,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  clb_config_chain_if.slave         bus,
  input  logic                      cfg_en_in,
  output logic                      cfg_en_out,
  output logic [(1<<LUT_K)-1:0]     lut,
  output logic                      mux_switch,
  output logic [NUM_IN*SEL_W-1:0]   icfg,
  output logic                      cfg_done,
  output logic                      cfg_err
);

  localparam int L      = 1 << LUT_K;
  localparam int ICFG_W = NUM_IN * SEL_W;
`ifdef CFG_PARITY_EN
  localparam int PAR_W  = 1;
`else
  localparam int PAR_W  = 0;
`endif
  localparam int FRAME_LEN = L + 1 + ICFG_W + PAR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
`ifdef CFG_PARITY_EN
    ,ST_ERR = 2'd3
`endif
  } state_t;

  // The XOR of the whole frame. Even parity means this is 0 for a good frame.
  function automatic logic frame_parity(input logic [FRAME_LEN-1:0] f);
    return ^f;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [FRAME_LEN-1:0]    sr_q, sr_d;
  logic [L-1:0]            lut_q, lut_d;
  logic                    sw_q, sw_d;
  logic [ICFG_W-1:0]       icfg_q, icfg_d;
  logic                    done_q, done_d;
  logic                    en_out_q, en_out_d;
`ifdef CFG_PARITY_EN
  logic                    err_q, err_d;
`endif

  logic                    accept_s;
  logic [FRAME_LEN-1:0]    sr_shift_s;

  assign accept_s   = bus.bit_valid && !bus.prgm_b && cfg_en_in &&
                      ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign sr_shift_s = {bus.bit_in, sr_q[FRAME_LEN-1:1]};

  // State, shift register, counter and the double-buffered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      sr_q     <= '0;
      lut_q    <= '0;
      sw_q     <= 1'b0;
      icfg_q   <= '0;
      done_q   <= 1'b0;
      en_out_q <= 1'b0;
`ifdef CFG_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      lut_q    <= lut_d;
      sw_q     <= sw_d;
      icfg_q   <= icfg_d;
      done_q   <= done_d;
      en_out_q <= en_out_d;
`ifdef CFG_PARITY_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic covering shifting, frame completion, abort and commit.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;
    lut_d   = lut_q;
    sw_d    = sw_q;
    icfg_d  = icfg_q;
    done_d  = done_q;
`ifdef CFG_PARITY_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (bus.prgm_b) begin
          // Program strobe released mid-frame: drop the partial frame.
          state_d = ST_IDLE;
          count_d = '0;
          sr_d    = '0;
        end else if (accept_s) begin
          sr_d = sr_shift_s;
`ifdef CFG_PARITY_EN
          if (state_q == ST_IDLE) begin
            err_d = 1'b0;
          end else begin
            err_d = err_q;
          end
`endif
          if (count_q == LAST_CNT) begin
            count_d = '0;
`ifdef CFG_PARITY_EN
            if (frame_parity(sr_shift_s)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = ST_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (bus.prgm_b) begin
          // Commit: move the shifted frame into the active outputs.
          lut_d   = sr_q[L-1:0];
          sw_d    = sr_q[L];
          icfg_d  = sr_q[L+1 +: ICFG_W];
          done_d  = 1'b1;
          sr_d    = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
`ifdef CFG_PARITY_EN
      ST_ERR: begin
        if (bus.prgm_b) begin
          // Leave the bad frame behind without committing it.
          state_d = ST_IDLE;
          count_d = '0;
          sr_d    = '0;
        end else begin
          state_d = ST_ERR;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        sr_d    = '0;
      end
    endcase
    // Registered from the next state, so the enable is high in the cycle
    // right after the last bit. The next bus bit then reaches the next tile.
    en_out_d = (state_d == ST_DONE) && !bus.prgm_b;
  end

  assign cfg_en_out = en_out_q;
  assign lut        = lut_q;
  assign mux_switch = sw_q;
  assign icfg       = icfg_q;
  assign cfg_done   = done_q;
`ifdef CFG_PARITY_EN
  assign cfg_err    = err_q;
`else
  assign cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_clb_config_chain.sv
// Directed bench for clb_config_chain.
// Two tiles are chained on one shared bus.
// The bench covers reset, single load and commit, the daisy chain, abort and
// hold, bit_valid gaps, and parity when CFG_PARITY_EN is defined.
module tb_clb_config_chain;
`ifdef CFG_PARITY_EN
  localparam int FR = 38;
`else
  localparam int FR = 37;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  clb_config_chain_if bus ();

  logic        eo0, sw0, done0, err0;
  logic [15:0] lut0;
  logic [19:0] icfg0;
  logic        eo1, sw1, done1, err1;
  logic [15:0] lut1;
  logic [19:0] icfg1;

  clb_config_chain u_t0 (
    .clk(clk), .reset(reset), .bus(bus), .cfg_en_in(1'b1),
    .cfg_en_out(eo0), .lut(lut0), .mux_switch(sw0), .icfg(icfg0),
    .cfg_done(done0), .cfg_err(err0)
  );

  clb_config_chain u_t1 (
    .clk(clk), .reset(reset), .bus(bus), .cfg_en_in(eo0),
    .cfg_en_out(eo1), .lut(lut1), .mux_switch(sw1), .icfg(icfg1),
    .cfg_done(done1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FR-1:0] make_frame(input logic [15:0] l, input logic s,
                                               input logic [19:0] ic);
    logic [FR-1:0] f;
    f = '0;
    f[36:0] = {ic, s, l};
`ifdef CFG_PARITY_EN
    f[37] = ^{ic, s, l};
`endif
    return f;
  endfunction

  // Drives n bits first bit first, with a 3-cycle bit_valid gap before each
  // index listed in g0, g1 and g2. It leaves bit_valid high after the last bit.
  task automatic send_frame(input logic [FR-1:0] f, input int n,
                            input int g0, input int g1, input int g2);
    for (int i = 0; i < n; i++) begin
      if (i == g0 || i == g1 || i == g2) begin
        repeat (3) begin
          @(negedge clk);
          bus.bit_valid = 1'b0;
          bus.bit_in    = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      bus.bit_in    = f[i];
      bus.bit_valid = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    bus.prgm_b = 1'b1;
    @(negedge clk);
  endtask

  logic [FR-1:0] fa, fb, fc, fd, fe, fbad;

  initial begin
    fa = make_frame(16'hA5C3, 1'b1, 20'h8421F);
    fb = make_frame(16'h1234, 1'b0, 20'hABCDE);
    fc = make_frame(16'h0F0F, 1'b1, 20'h00001);
    fd = make_frame(16'h5555, 1'b1, 20'h7A5A5);
    fe = make_frame(16'hC3C3, 1'b0, 20'h12345);
    fbad = fa;
    fbad[FR-1] = ~fbad[FR-1];

    reset         = 1'b1;
    bus.prgm_b    = 1'b1;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_lut", 32'(lut0), 32'h0);
    chk("rst_icfg", 32'(icfg0), 32'h0);
    chk("rst_sw", 32'(sw0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    chk("rst_eo", 32'(eo0), 32'h0);

    // Single-frame load, checking exactly when cfg_en_out rises.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fa, FR - 1, -1, -1, -1);
    @(negedge clk);
    chk("eo_before_last", 32'(eo0), 32'h0);
    bus.bit_in    = fa[FR-1];
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    chk("eo_after_last", 32'(eo0), 32'h1);
    chk("lut_pre_commit", 32'(lut0), 32'h0);
    chk("done_pre_commit", 32'(done0), 32'h0);
    @(negedge clk);
    chk("eo_hold_done", 32'(eo0), 32'h1);
    commit();
    chk("a_lut", 32'(lut0), 32'h0000A5C3);
    chk("a_sw", 32'(sw0), 32'h1);
    chk("a_icfg", 32'(icfg0), 32'h0008421F);
    chk("a_done", 32'(done0), 32'h1);
    chk("a_eo_fall", 32'(eo0), 32'h0);
    chk("a_t1_idle", 32'(done1), 32'h0);

    // Reset 10 bits into a frame clears everything; the next frame starts at bit 0.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fb, 10, -1, -1, -1);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_lut", 32'(lut0), 32'h0);
    chk("midrst_icfg", 32'(icfg0), 32'h0);
    chk("midrst_done", 32'(done0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(fa, FR, -1, -1, -1);
    idle();
    commit();
    chk("reload_lut", 32'(lut0), 32'h0000A5C3);
    chk("reload_icfg", 32'(icfg0), 32'h0008421F);

    // Daisy chain: two frames back to back with no idle cycle between them.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fb, FR, -1, -1, -1);
    send_frame(fc, FR, -1, -1, -1);
    idle();
    chk("chain_eo0", 32'(eo0), 32'h1);
    chk("chain_eo1", 32'(eo1), 32'h1);
    commit();
    chk("chain_lut0", 32'(lut0), 32'h00001234);
    chk("chain_sw0", 32'(sw0), 32'h0);
    chk("chain_icfg0", 32'(icfg0), 32'h000ABCDE);
    chk("chain_lut1", 32'(lut1), 32'h00000F0F);
    chk("chain_sw1", 32'(sw1), 32'h1);
    chk("chain_icfg1", 32'(icfg1), 32'h00000001);
    chk("chain_done1", 32'(done1), 32'h1);
    chk("chain_eo1_fall", 32'(eo1), 32'h0);

    // Abort after 20 bits: the committed values hold, then a fresh frame loads.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fd, 20, -1, -1, -1);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.prgm_b    = 1'b1;
    @(negedge clk);
    chk("abort_lut_hold", 32'(lut0), 32'h00001234);
    chk("abort_icfg_hold", 32'(icfg0), 32'h000ABCDE);
    chk("abort_eo", 32'(eo0), 32'h0);
    bus.prgm_b = 1'b0;
    send_frame(fd, FR, -1, -1, -1);
    idle();
    commit();
    chk("d_lut", 32'(lut0), 32'h00005555);
    chk("d_sw", 32'(sw0), 32'h1);
    chk("d_icfg", 32'(icfg0), 32'h0007A5A5);

    // bit_valid gaps carrying junk data must not disturb the frame.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fe, FR, 5, 17, 30);
    idle();
    commit();
    chk("gap_lut", 32'(lut0), 32'h0000C3C3);
    chk("gap_sw", 32'(sw0), 32'h0);
    chk("gap_icfg", 32'(icfg0), 32'h00012345);
    chk("gap_t1_hold", 32'(lut1), 32'h00000F0F);

`ifdef CFG_PARITY_EN
    // A bad parity bit halts the chain and blocks the commit.
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fbad, FR, -1, -1, -1);
    idle();
    chk("par_err", 32'(err0), 32'h1);
    chk("par_eo", 32'(eo0), 32'h0);
    commit();
    chk("par_no_commit", 32'(lut0), 32'h0000C3C3);
    chk("par_err_sticky", 32'(err0), 32'h1);
    @(negedge clk);
    bus.prgm_b = 1'b0;
    send_frame(fa, FR, -1, -1, -1);
    idle();
    chk("par_err_clear", 32'(err0), 32'h0);
    commit();
    chk("par_good_lut", 32'(lut0), 32'h0000A5C3);
`else
    chk("noparity_err", 32'(err0), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clb_config_chain.md
Name: clb_config_chain

Overview:
- Parametrised serial configuration loader for one CLB tile.
- Shifts a frame containing the LUT truth table, the output-mux select bit and the per-input interconnect selects off a shared serial bus.
- Tiles are daisy-chained through cfg_en_in/cfg_en_out, so consecutive tiles load back-to-back with no idle cycle between them.
- Loaded values are double-buffered: active outputs change only at commit, when prgm_b returns high.

Parameters:
- LUT_K, 4: LUT input count; the truth table is L = 2**LUT_K bits.
- NUM_IN, 4: number of interconnect-routed LUT inputs.
- SEL_W, 5: select width per input.
- Derived: FRAME_LEN = L + 1 + NUM_IN*SEL_W (default 37). It is one greater when CFG_PARITY_EN is defined.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- prgm_b, input, 1: global program strobe; 0 = programming mode, 1 = run mode.
- cfg_en_in, input, 1: chain enable from the previous tile. Tied 1 on the first tile.
- bit_in, input, 1: shared serial config data.
- bit_valid, input, 1: bit_in is valid this cycle.
- cfg_en_out, output, 1: this tile has consumed its frame; enables the next tile.
- lut, output, L: active LUT truth table.
- mux_switch, output, 1: active output-mux select.
- icfg, output, NUM_IN*SEL_W: active interconnect selects; input n occupies [n*SEL_W +: SEL_W].
- cfg_done, output, 1: sticky; at least one successful commit has occurred since reset.
- cfg_err, output, 1: parity failure flag. Constant 0 without CFG_PARITY_EN.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Bit counter, shift register, lut, mux_switch, icfg, cfg_en_out, cfg_done and cfg_err all clear to 0.
  - Reset takes effect mid-frame, aborting the frame immediately.
- States: IDLE, LOAD, DONE, plus ERR when parity is enabled.
- Accept condition: accept = bit_valid && !prgm_b && cfg_en_in && state in {IDLE, LOAD}.
  - accept is combinational, so a tile starts consuming in the same cycle its cfg_en_in rises.
- Shifting: on accept, sr <= {bit_in, sr[FRAME_LEN-1:1]} and count increments.
  - Counter width is $clog2(FRAME_LEN+1).
- Frame bit order, first bit first: lut[0]..lut[L-1], mux_switch, icfg[0]..icfg[NUM_IN*SEL_W-1], then parity if enabled.
  - After a full frame, sr = {[parity,] icfg, mux_switch, lut}.
- State transitions:
  - IDLE -> LOAD on the first accept.
  - LOAD -> DONE on the edge that accepts bit number FRAME_LEN (count == FRAME_LEN-1 at that edge). The counter clears on the same edge.
- cfg_en_out:
  - cfg_en_out = (state == DONE) && !prgm_b, registered.
  - It is high in the cycle immediately after the last bit, so the next bus bit goes to the next tile.
- Bits while cfg_en_in = 0 or in DONE: ignored, no shift.
- Abort: prgm_b rising while in IDLE or LOAD returns the tile to IDLE.
  - Counter and sr are cleared.
  - Active outputs and cfg_done are unchanged.
- Commit: prgm_b == 1 while in DONE, in that cycle:
  - Copy sr fields to lut, mux_switch and icfg.
  - Set cfg_done.
  - Go to IDLE; cfg_en_out falls.
  - Commit latency: outputs valid on the first clk edge after prgm_b rises.
- Reprogramming: prgm_b low again starts a new frame. The old active values are held until the next commit.
- Simultaneous accept and prgm_b rise: impossible by definition, because accept requires !prgm_b.

Optional Feature:
- CFG_PARITY_EN defined:
  - The frame gains one trailing even-parity bit; the XOR of all FRAME_LEN bits must be 0.
  - On a mismatch at the completing edge, the state goes to ERR instead of DONE, cfg_err = 1, and cfg_en_out stays 0, halting the chain.
  - prgm_b rising in ERR returns the tile to IDLE with no commit. cfg_err stays set until the next accepted first bit or reset.
- CFG_PARITY_EN undefined: there is no parity bit, the ERR state is absent, and cfg_err is tied 0.

Test Plan:
- Reset behaviour: reset asserted mid-frame after 10 bits -> all outputs 0, state IDLE. The next frame loads from bit 0.
- Single-frame load (defaults): prgm_b = 0, cfg_en_in = 1, stream 37 bits with lut = 16'hA5C3, switch = 1, icfg = 20'h8421F. Then:
  - cfg_en_out goes high in cycle 38.
  - Outputs stay 0 until prgm_b rises.
  - One edge later, lut = A5C3, mux_switch = 1, icfg = 8421F, cfg_done = 1.
- Daisy chain: two instances, 74 contiguous valid bits -> the second tile takes bits 38..74 with no gap, and both commit the correct values.
- Abort and hold: commit frame A, start frame B, raise prgm_b after 20 bits -> outputs still equal A, and the counter restarts from 0 on the next frame.
- bit_valid gaps: deassert bit_valid for 3 cycles at random points -> the same result as the contiguous load.
- Parity (CFG_PARITY_EN): send a 38-bit frame with a flipped parity bit -> cfg_err = 1, cfg_en_out = 0, and no commit on the prgm_b rise. A correct frame afterwards clears cfg_err and commits.
